// File: rtl/fifo_rd_pkg.sv
// Shared constants, types and helpers for the FIFO stream reader.
package fifo_rd_pkg;

  localparam int unsigned BUF_DEPTH = 3;
  localparam int unsigned PTR_W     = 2;
  localparam int unsigned OCC_W     = 2;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [OCC_W-1:0] occ_t;

  // Bits needed to index n lanes; never less than 1 so the lane register stays legal.
  function automatic int unsigned lane_idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  // Circular pointer advance modulo BUF_DEPTH.
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready lane stream produced by the FIFO stream reader.
interface fifo_stream_reader_if #(
  parameter int unsigned OUT_WIDTH = 16
);
  logic                 m_valid;
  logic                 m_ready;
  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_rd_word_buf.sv
// Three-entry circular word buffer: captures popped FIFO words, exposes the head.
module fifo_rd_word_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;

  // Storage, pointers and occupancy; simultaneous write and read leave occ unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + occ_t'(1);
        2'b01:   occ <= occ - occ_t'(1);
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a non-fall-through FIFO into a valid/ready lane stream, LSB lane first.
// Optional statistics counters are enabled with `define FIFO_RD_STATS_EN.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned OUT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  output logic                    fifo_pop,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  fifo_stream_reader_if.master    stream
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]             stat_words,
  output logic [31:0]             stat_stalls
`endif
);

  localparam int unsigned RATIO  = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned LANE_W = lane_idx_w(RATIO);

  logic                  inflight;
  occ_t                  occ;
  logic [DATA_WIDTH-1:0] head;
  logic [OCC_W:0]        credit_used;
  logic                  xfer;
  logic                  word_done;

  // Credit covers both stored and in-flight words, so a capture never hits a full buffer
  // and pop never depends on downstream ready.
  assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign fifo_pop    = !reset && !fifo_empty && (credit_used < (OCC_W+1)'(BUF_DEPTH));

  // A pop this cycle means FIFO data arrives next cycle.
  always_ff @(posedge clk) begin
    if (reset) inflight <= 1'b0;
    else       inflight <= fifo_pop;
  end

  assign stream.m_valid = (occ != '0);
  assign xfer           = stream.m_valid && stream.m_ready;
  assign word_done      = xfer && stream.m_last;

  fifo_rd_word_buf #(.DATA_WIDTH(DATA_WIDTH)) u_word_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight),
    .wr_data (fifo_data),
    .rd_en   (word_done),
    .head    (head),
    .occ     (occ)
  );

  generate
    if (RATIO > 1) begin : g_lanes
      logic [LANE_W-1:0] lane;

      // Lane serializer: advance per transfer, wrap to 0 after the last lane.
      always_ff @(posedge clk) begin
        if (reset)     lane <= '0;
        else if (xfer) lane <= stream.m_last ? '0 : lane + LANE_W'(1);
      end

      assign stream.m_last = (lane == LANE_W'(RATIO - 1));
      assign stream.m_data = head[int'(lane)*OUT_WIDTH +: OUT_WIDTH];
    end else begin : g_single
      assign stream.m_last = 1'b1;
      assign stream.m_data = head;
    end
  endgenerate

`ifdef FIFO_RD_STATS_EN
  // Saturating counts of FIFO pops and downstream back-pressure cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (fifo_pop && (stat_words != '1))
        stat_words <= stat_words + 32'd1;
      if (stream.m_valid && !stream.m_ready && (stat_stalls != '1))
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: FIFO models feed a 4-lane and a 1-lane instance,
// a lane queue predicts the output stream.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 64;
  localparam int unsigned OW = 16;
  localparam int unsigned R  = DW / OW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: 64-bit words, 16-bit lanes ----------------
  fifo_stream_reader_if #(.OUT_WIDTH(OW)) sa ();
  logic          a_empty, a_pop;
  logic [DW-1:0] a_data = '0;
  logic [DW-1:0] a_mem [256];
  int unsigned   a_wr = 0, a_rd = 0;
  assign a_empty = (a_wr == a_rd);

  // registered-read FIFO: data appears the cycle after the pop
  always @(posedge clk) begin
    if (reset) a_rd <= a_wr;
    else if (a_pop) begin
      a_data <= a_mem[a_rd % 256];
      a_rd   <= a_rd + 1;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [31:0] a_stat_words, a_stat_stalls, b_stat_words, b_stat_stalls;
`endif

  fifo_stream_reader #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (a_empty),
    .fifo_pop   (a_pop),
    .fifo_data  (a_data),
    .stream     (sa)
`ifdef FIFO_RD_STATS_EN
    ,
    .stat_words (a_stat_words),
    .stat_stalls(a_stat_stalls)
`endif
  );

  logic [OW:0] a_exp [$];
  int unsigned a_pops = 0;
  logic        a_prev_stall = 1'b0;
  logic [OW:0] a_prev = '0;

  task automatic push_a(input logic [DW-1:0] w);
    a_mem[a_wr % 256] = w;
    a_wr++;
    for (int unsigned i = 0; i < R; i++)
      a_exp.push_back({(i == R - 1), OW'(w >> (OW * i))});
  endtask

  // monitor A: order, lane content, hold-under-stall, no pop on empty
  always @(negedge clk) begin
    logic [OW:0] e;
    if (reset) begin
      a_exp.delete();
      a_prev_stall = 1'b0;
    end else begin
      if (a_pop) begin
        a_pops++;
        check_eq("a_pop_when_empty", a_empty, 1'b0);
      end
      if (a_prev_stall)
        check_eq("a_hold", {sa.m_valid, sa.m_last, sa.m_data}, {1'b1, a_prev});
      if (sa.m_valid && sa.m_ready) begin
        check_eq("a_xfer_expected", (a_exp.size() != 0), 1'b1);
        if (a_exp.size() != 0) begin
          e = a_exp.pop_front();
          check_eq("a_lane", {sa.m_last, sa.m_data}, e);
        end
      end
      a_prev_stall = sa.m_valid && !sa.m_ready;
      a_prev       = {sa.m_last, sa.m_data};
    end
  end

  // ---------------- instance B: RATIO == 1 ----------------
  fifo_stream_reader_if #(.OUT_WIDTH(OW)) sb ();
  logic          b_empty, b_pop;
  logic [OW-1:0] b_data = '0;
  logic [OW-1:0] b_mem [256];
  int unsigned   b_wr = 0, b_rd = 0;
  assign b_empty = (b_wr == b_rd);

  // registered-read FIFO for instance B
  always @(posedge clk) begin
    if (reset) b_rd <= b_wr;
    else if (b_pop) begin
      b_data <= b_mem[b_rd % 256];
      b_rd   <= b_rd + 1;
    end
  end

  fifo_stream_reader #(.DATA_WIDTH(OW), .OUT_WIDTH(OW)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (b_empty),
    .fifo_pop   (b_pop),
    .fifo_data  (b_data),
    .stream     (sb)
`ifdef FIFO_RD_STATS_EN
    ,
    .stat_words (b_stat_words),
    .stat_stalls(b_stat_stalls)
`endif
  );

  logic [OW-1:0] b_exp [$];

  task automatic push_b(input logic [OW-1:0] w);
    b_mem[b_wr % 256] = w;
    b_wr++;
    b_exp.push_back(w);
  endtask

  // monitor B: word order and m_last always set
  always @(negedge clk) begin
    logic [OW-1:0] e;
    if (reset) b_exp.delete();
    else if (sb.m_valid && sb.m_ready) begin
      check_eq("b_xfer_expected", (b_exp.size() != 0), 1'b1);
      if (b_exp.size() != 0) begin
        e = b_exp.pop_front();
        check_eq("b_word", {sb.m_last, sb.m_data}, {1'b1, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   t, pops0, pr, pv, maxp, maxv;
    logic [DW-1:0] w0;

    sa.m_ready = 1'b0;
    sb.m_ready = 1'b1;

    // reset state
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check_eq("rst_pop",    a_pop, 1'b0);
    check_eq("rst_valid",  sa.m_valid, 1'b0);
    check_eq("rst_data",   sa.m_data, 16'h0);
    check_eq("rst_last",   sa.m_last, 1'b0);
    check_eq("rst_b_last", sb.m_last, 1'b1);
`ifdef FIFO_RD_STATS_EN
    check_eq("rst_stat_words",  a_stat_words, 32'd0);
    check_eq("rst_stat_stalls", a_stat_stalls, 32'd0);
`endif
    tick();
    reset = 1'b0;

    // single word, ready high: latency and lane order
    sa.m_ready = 1'b1;
    push_a(64'h4444_3333_2222_1111);
    @(negedge clk);
    check_eq("t1_pop", a_pop, 1'b1);
    t = 0;
    while (!sa.m_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("t1_latency", t, 2);
    for (int unsigned i = 0; i < 4; i++) begin
      check_eq("t1_valid", sa.m_valid, 1'b1);
      check_eq("t1_data",  sa.m_data, 16'h1111 * (i + 1));
      check_eq("t1_last",  sa.m_last, (i == 3));
      @(negedge clk);
    end
    check_eq("t1_idle", sa.m_valid, 1'b0);

    // back-pressure with a full FIFO: exactly three pops
    tick();
    sa.m_ready = 1'b0;
    pops0 = a_pops;
    w0 = {$urandom, $urandom};
    push_a(w0);
    for (int i = 0; i < 5; i++) push_a({$urandom, $urandom});
    repeat (10) @(negedge clk);
    check_eq("t3_pops",  a_pops - pops0, 3);
    check_eq("t3_nopop", a_pop, 1'b0);
    check_eq("t3_valid", sa.m_valid, 1'b1);
    check_eq("t3_hold",  sa.m_data, w0[15:0]);
    tick();
    sa.m_ready = 1'b1;
    t = 0;
    while (a_exp.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check_eq("t3_drained", a_exp.size(), 0);
    check_eq("t3_fifo_empty", a_empty, 1'b1);
    check_eq("t3_idle", sa.m_valid, 1'b0);

    // FIFO goes empty while the popped word is still in flight
    tick();
    pops0 = a_pops;
    push_a({$urandom, $urandom});
    @(negedge clk);
    check_eq("t4_pop", a_pop, 1'b1);
    @(negedge clk);
    check_eq("t4_empty_inflight", a_empty, 1'b1);
    check_eq("t4_no_pop", a_pop, 1'b0);
    repeat (8) @(negedge clk);
    check_eq("t4_one_pop", a_pops - pops0, 1);
    check_eq("t4_emitted", a_exp.size(), 0);

    // reset with two words buffered and one in flight
    tick();
    sa.m_ready = 1'b0;
    pops0 = a_pops;
    for (int i = 0; i < 5; i++) push_a({$urandom, $urandom});
    repeat (3) @(negedge clk);
    tick();
    check_eq("t5_pops_before", a_pops - pops0, 3);
    reset = 1'b1;
    #1;
    check_eq("t5_pop_in_reset", a_pop, 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_valid", sa.m_valid, 1'b0);
    check_eq("t5_pop",   a_pop, 1'b0);
    check_eq("t5_data",  sa.m_data, 16'h0);
    tick();
    sa.m_ready = 1'b1;
    push_a(64'hA5);
    t = 0;
    while (!sa.m_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("t5_first_lane", sa.m_data, 16'h00A5);
    repeat (8) @(negedge clk);
    check_eq("t5_drained", a_exp.size(), 0);

    // RATIO == 1 streaming: 100 pops and 100 valids back to back
    tick();
    for (int i = 0; i < 100; i++) push_b(16'($urandom));
    pr = 0; pv = 0; maxp = 0; maxv = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      pr = b_pop ? pr + 1 : 0;
      pv = sb.m_valid ? pv + 1 : 0;
      if (pr > maxp) maxp = pr;
      if (pv > maxv) maxv = pv;
    end
    check_eq("t2_pop_run",   maxp, 100);
    check_eq("t2_valid_run", maxv, 100);
    check_eq("t2_drained",   b_exp.size(), 0);

    // randomized traffic against the lane queue
    for (int i = 0; i < 400; i++) begin
      tick();
      sa.m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0 && (a_wr - a_rd) < 200)
        push_a({$urandom, $urandom});
    end
    tick();
    sa.m_ready = 1'b1;
    t = 0;
    while ((a_exp.size() != 0 || !a_empty) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check_eq("rand_drained", a_exp.size(), 0);
    check_eq("rand_idle", sa.m_valid, 1'b0);

`ifdef FIFO_RD_STATS_EN
    // statistics: 5 words, 7 stall cycles
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    sa.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_a({$urandom, $urandom});
    t = 0;
    while (!sa.m_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (7) @(posedge clk);
    #1;
    sa.m_ready = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("t6_drained",     a_exp.size(), 0);
    check_eq("t6_stat_words",  a_stat_words, 32'd5);
    check_eq("t6_stat_stalls", a_stat_stalls, 32'd7);
    check_eq("t6_b_stat_words", b_stat_words, 32'd0);
    check_eq("t6_b_stat_stalls", b_stat_stalls, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
